// File: rtl/bus_slave_if_pkg.sv
// Shared constants for the bus slave: state encodings, bus polarity and word widths.
// The optional BUS_SLAVE_TIMEOUT_EN build uses sat_inc8 for the error counter.
package bus_slave_if_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int ERR_CNT_W   = 8;
    localparam int TIMER_W     = 8;

    localparam logic [1:0] BUS_SLAVE_STATE_IDLE  = 2'd0;
    localparam logic [1:0] BUS_SLAVE_STATE_WAIT  = 2'd1;
    localparam logic [1:0] BUS_SLAVE_STATE_LOCAL = 2'd2;
    localparam logic [1:0] BUS_SLAVE_STATE_RESP  = 2'd3;

    // Bus strobes and ready are active low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef logic [WORD_DATA_W-1:0] word_data_t;
    typedef logic [WORD_ADDR_W-1:0] word_addr_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bus_slave_timer.sv
// Loadable down-counter with a zero flag; shared by the wait-state and timeout counts.
module bus_slave_timer
    import bus_slave_if_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/bus_slave_if.sv
// Bus responder: turns a strobed bus access into a local req/ack handshake and a rdy_ pulse.
// Define BUS_SLAVE_TIMEOUT_EN to abort unanswered local requests and count them in err_cnt.
module bus_slave_if
    import bus_slave_if_pkg::*;
#(
    parameter int LOC_AW   = 12,
    parameter int WAIT_MIN = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_,
    output logic                   loc_req,
    output logic                   loc_rw,
    output logic [LOC_AW-1:0]      loc_addr,
    output logic [WORD_DATA_W-1:0] loc_wr_data,
    input  logic                   loc_ack,
    input  logic [WORD_DATA_W-1:0] loc_rd_data,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(WAIT_MIN - 1);
    localparam logic [TIMER_W-1:0] TMO_LOAD  = TIMER_W'(TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [WORD_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                   loc_req_q, loc_req_d;
    logic                   loc_rw_q, loc_rw_d;
    logic [LOC_AW-1:0]      loc_addr_q, loc_addr_d;
    logic [WORD_DATA_W-1:0] loc_wr_data_q, loc_wr_data_d;

    logic               timer_load;
    logic               timer_dec;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_zero;

`ifdef BUS_SLAVE_TIMEOUT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        rdy_d          = rdy_q;
        rd_data_d      = rd_data_q;
        loc_req_d      = loc_req_q;
        loc_rw_d       = loc_rw_q;
        loc_addr_d     = loc_addr_q;
        loc_wr_data_d  = loc_wr_data_q;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;
        timer_load_val = TMO_LOAD;
`ifdef BUS_SLAVE_TIMEOUT_EN
        err_cnt_d      = err_cnt_q;
`endif
        case (state_q)
            BUS_SLAVE_STATE_IDLE: begin
                if ((cs_ == ENABLE_) && (as_ == ENABLE_)) begin
                    loc_rw_d      = rw;
                    loc_addr_d    = addr[LOC_AW-1:0];
                    loc_wr_data_d = wr_data;
                    timer_load    = 1'b1;
                    if (WAIT_MIN > 0) begin
                        state_d        = BUS_SLAVE_STATE_WAIT;
                        timer_load_val = WAIT_LOAD;
                    end else begin
                        state_d   = BUS_SLAVE_STATE_LOCAL;
                        loc_req_d = 1'b1;
                    end
                end
            end
            BUS_SLAVE_STATE_WAIT: begin
                // Entering LOCAL reloads the same timer for the ack timeout.
                if (timer_zero) begin
                    state_d    = BUS_SLAVE_STATE_LOCAL;
                    loc_req_d  = 1'b1;
                    timer_load = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            BUS_SLAVE_STATE_LOCAL: begin
                if (loc_ack) begin
                    loc_req_d = 1'b0;
                    rd_data_d = (loc_rw_q == READ) ? loc_rd_data : '0;
                    rdy_d     = ENABLE_;
                    state_d   = BUS_SLAVE_STATE_RESP;
                end
`ifdef BUS_SLAVE_TIMEOUT_EN
                else if (timer_zero) begin
                    loc_req_d = 1'b0;
                    rd_data_d = '0;
                    rdy_d     = ENABLE_;
                    state_d   = BUS_SLAVE_STATE_RESP;
                    err_cnt_d = sat_inc8(err_cnt_q);
                end else begin
                    timer_dec = 1'b1;
                end
`endif
            end
            BUS_SLAVE_STATE_RESP: begin
                rdy_d     = DISABLE_;
                rd_data_d = '0;
                state_d   = BUS_SLAVE_STATE_IDLE;
            end
            default: begin
                state_d = BUS_SLAVE_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BUS_SLAVE_STATE_IDLE;
            rdy_q         <= DISABLE_;
            rd_data_q     <= '0;
            loc_req_q     <= 1'b0;
            loc_rw_q      <= READ;
            loc_addr_q    <= '0;
            loc_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= rdy_d;
            rd_data_q     <= rd_data_d;
            loc_req_q     <= loc_req_d;
            loc_rw_q      <= loc_rw_d;
            loc_addr_q    <= loc_addr_d;
            loc_wr_data_q <= loc_wr_data_d;
        end
    end

`ifdef BUS_SLAVE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    bus_slave_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    // Upper address bits select the slave in the decoder and are not needed here.
    generate
        if (LOC_AW < WORD_ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[WORD_ADDR_W-1:LOC_AW];
        end
    endgenerate

    assign rdy_        = rdy_q;
    assign rd_data     = rd_data_q;
    assign loc_req     = loc_req_q;
    assign loc_rw      = loc_rw_q;
    assign loc_addr    = loc_addr_q;
    assign loc_wr_data = loc_wr_data_q;

endmodule

// File: doc/bus_slave_if.md
# bus_slave_if

Responder end of the shared CPU bus: sits behind the address decoder in front of each peripheral and accepts single-word accesses from the bus master, including strobe `as_`, direction `rw`, address and write data. It converts each access into a req/ack handshake on a simple local port and answers the master with a one-cycle active-low `rdy_` pulse. On reads, `rd_data` carries the data during that pulse. All bus-side outputs are registered. `rd_data` is zero outside the ready cycle, so the bus can OR-combine the outputs of several slaves.

## Interface
Parameters:
- LOC_AW, 12: local word-address width; local address is bus `addr[LOC_AW-1:0]`.
- WAIT_MIN, 0: fixed wait cycles inserted between strobe capture and `loc_req` (0..15).
- TIMEOUT, 255: `loc_ack` timeout in cycles, 1..255 (used only with BUS_SLAVE_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cs_  in  1  chip select from address decoder, active low
- as_  in  1  address strobe, active low, one-cycle pulse from master
- rw  in  1  1 = read, 0 = write
- addr  in  30  word address, stable from strobe until `rdy_`
- wr_data  in  32  write data, stable from strobe until `rdy_`
- rd_data  out  32  read data, valid only while `rdy_`=0, else 0
- rdy_  out  1  ready, active low, one-cycle pulse
- loc_req  out  1  local request, held until acked
- loc_rw  out  1  local direction
- loc_addr  out  LOC_AW  local word address
- loc_wr_data  out  32  local write data
- loc_ack  in  1  local acknowledge, sampled on clk edge
- loc_rd_data  in  32  local read data, valid with `loc_ack`
- err_cnt  out  8  saturating count of timed-out accesses

## Operation
- Reset values: `rdy_`=1, `rd_data`=0, `loc_req`=0, `loc_rw`=1, `loc_addr`=0, `loc_wr_data`=0, `err_cnt`=0, state IDLE.
- States: IDLE, WAIT, LOCAL, RESP.
- IDLE:
  - Accept when `cs_`=0 and `as_`=0 on an edge.
  - Latch `rw`, `addr[LOC_AW-1:0]` and `wr_data` into the `loc_*` registers.
  - Go to WAIT with counter = WAIT_MIN-1 if WAIT_MIN>0, else go to LOCAL with `loc_req`←1.
- WAIT: decrement counter; at 0, go to LOCAL with `loc_req`←1.
- LOCAL:
  - On an edge with `loc_ack`=1: `loc_req`←0; if read, `rd_data`←`loc_rd_data`, else `rd_data`←0; `rdy_`←0; go to RESP.
- RESP: `rdy_`←1, `rd_data`←0; go to IDLE.
- Strobes arriving outside IDLE, or with `cs_`=1, are ignored (no queueing).
- `loc_ack` outside LOCAL is ignored.
- Reset at any point: next edge forces reset values; no `rdy_` pulse is emitted for an aborted access.

## Timing
- Strobe sampled at edge E0.
- `loc_req` high from E0+1+WAIT_MIN.
- `loc_ack` sampled at edge Ea, giving `rdy_`=0 during the cycle after Ea, for exactly one cycle.
- Minimum latency with WAIT_MIN=0 and `loc_ack` high in the first `loc_req` cycle: `rdy_` low in cycle E0+2.
- Back-to-back: a strobe is accepted again at the first edge in which the state is IDLE, which is 1 cycle after `rdy_` deasserts.

## Configuration
- BUS_SLAVE_TIMEOUT_EN defined:
  - A counter runs while in LOCAL.
  - If `loc_ack` has not been sampled after TIMEOUT cycles: `loc_req`←0, `rd_data`←32'h0, `rdy_`←0, go to RESP, `err_cnt` += 1 (saturating at 255).
  - `loc_ack` on the same edge as expiry wins (normal completion, no error).
- Undefined: LOCAL waits indefinitely; `err_cnt` is tied to 0. Port list is identical in both builds.

## Structure
- Shared header `bus_slave_if.h`:
  - State encodings BUS_SLAVE_STATE_IDLE/WAIT/LOCAL/RESP (2-bit).
  - The global ENABLE_/DISABLE_ and READ/WRITE constants.
  - WORD_DATA_W and WORD_ADDR_W.
- One sub-module is natural: `bus_slave_timer`, a loadable down-counter with a zero flag, used for both the WAIT_MIN count and the timeout count (the two are never active together). Everything else stays in `bus_slave_if`.

## Test plan
- Read, WAIT_MIN=0, `loc_ack` same cycle as `loc_req`, `loc_rd_data`=32'h1234_5678 -> `rdy_` low in cycle E0+2 only, `rd_data`=32'h1234_5678 in that cycle, 0 otherwise.
- Write, addr=30'h0000_0ABC, `wr_data`=32'hCAFE_F00D, WAIT_MIN=3, `loc_ack` after 2 cycles -> `loc_req` rises at E0+4 with `loc_addr`=12'hABC and `loc_wr_data`=32'hCAFE_F00D; `rdy_` low once; `rd_data` stays 0.
- Strobe with `cs_`=1, then a strobe during LOCAL -> no `loc_req` for the first; the second is ignored and the original access completes unchanged.
- Reset asserted while `loc_req`=1 -> `loc_req`=0 and `rdy_`=1 after the next edge; no `rdy_` pulse; the next strobe is handled normally.
- BUS_SLAVE_TIMEOUT_EN, TIMEOUT=8, `loc_ack` never asserted -> `rdy_` low after 8 LOCAL cycles, `rd_data`=0, `err_cnt`=1; 256 such accesses leave `err_cnt`=255.
- BUS_SLAVE_TIMEOUT_EN, `loc_ack` on the expiry edge -> normal completion, `rd_data`=`loc_rd_data`, `err_cnt` unchanged.
